// File: rtl/spram_arb_pkg.sv
// rtl/spram_arb_pkg.sv - shared constants and requester index type for the SPRAM arbiter
package spram_arb_pkg;

    localparam int SPRAM_AW = 4;
    localparam int SPRAM_DW = 8;
    localparam int STAT_W   = 16;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_idx_e;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick: priority pointer register and grant logic
module rr_pick2
    import spram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       prio_nxt
);

    // 0: A wins a tie, 1: B wins a tie
    logic prio;

    // Grant the lone requester, or the pointer side on contention; pointer moves to the loser
    always_comb begin
        gnt           = '0;
        gnt[REQ_A]    = req[REQ_A] & (~req[REQ_B] | ~prio);
        gnt[REQ_B]    = req[REQ_B] & (~req[REQ_A] |  prio);
        prio_nxt      = prio;
        if (gnt[REQ_A]) begin
            prio_nxt = 1'b1;
        end else if (gnt[REQ_B]) begin
            prio_nxt = 1'b0;
        end
    end

    // Pointer register; holds when nothing is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else begin
            prio <= prio_nxt;
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - two-master round-robin front end for a single-port RAM (optional SPRAM_ARB_STATS_EN grant counters)
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int AW = SPRAM_AW,
    parameter int DW = SPRAM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_wr,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_wr,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
`ifdef SPRAM_ARB_STATS_EN
    input  logic              stat_clr,
    output logic [STAT_W-1:0] a_cnt,
    output logic [STAT_W-1:0] b_cnt,
`endif
    output logic          ram_en,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       prio_nxt;
    logic       rd_pend_a;
    logic       rd_pend_b;

    // Requests are masked while reset is held so nothing reaches the RAM
    assign req[REQ_A] = a_req & rst_n;
    assign req[REQ_B] = b_req & rst_n;

    rr_pick2 u_pick (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .prio_nxt (prio_nxt)
    );

    assign a_gnt = gnt[REQ_A];
    assign b_gnt = gnt[REQ_B];

    // RAM command comes from the granted side; all-zero when idle
    always_comb begin
        ram_en   = 1'b0;
        ram_wr   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (gnt[REQ_A]) begin
            ram_en   = 1'b1;
            ram_wr   = a_wr;
            ram_addr = a_addr;
            ram_din  = a_wdata;
        end else if (gnt[REQ_B]) begin
            ram_en   = 1'b1;
            ram_wr   = b_wr;
            ram_addr = b_addr;
            ram_din  = b_wdata;
        end
    end

    // Remember who issued a read so the next cycle's RAM output is steered back to it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_a <= 1'b0;
            rd_pend_b <= 1'b0;
        end else begin
            rd_pend_a <= gnt[REQ_A] & ~a_wr;
            rd_pend_b <= gnt[REQ_B] & ~b_wr;
        end
    end

    assign a_rvalid = rd_pend_a;
    assign b_rvalid = rd_pend_b;
    assign a_rdata  = rd_pend_a ? ram_dout : '0;
    assign b_rdata  = rd_pend_b ? ram_dout : '0;

`ifdef SPRAM_ARB_STATS_EN
    // Saturating per-requester grant counters; clear wins over a same-cycle grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt <= '0;
            b_cnt <= '0;
        end else if (stat_clr) begin
            a_cnt <= '0;
            b_cnt <= '0;
        end else begin
            if (gnt[REQ_A] && (a_cnt != '1)) begin
                a_cnt <= a_cnt + 1'b1;
            end
            if (gnt[REQ_B] && (b_cnt != '1)) begin
                b_cnt <= b_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - directed vector bench for spram_arbiter with a behavioural single-port RAM
module tb_spram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req, a_wr, b_req, b_wr;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_en, ram_wr;
    logic [3:0] ram_addr;
    logic [7:0] ram_din, ram_dout;
`ifdef SPRAM_ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] a_cnt, b_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spram_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_wr     (a_wr),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_wr     (b_wr),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
`ifdef SPRAM_ARB_STATS_EN
        .stat_clr (stat_clr),
        .a_cnt    (a_cnt),
        .b_cnt    (b_cnt),
`endif
        .ram_en   (ram_en),
        .ram_wr   (ram_wr),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // Behavioural single_port_ram
    logic [7:0] mem [0:15];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        ram_dout = 8'h00;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    typedef struct {
        logic       a_req; logic a_wr; logic [3:0] a_addr; logic [7:0] a_wdata;
        logic       b_req; logic b_wr; logic [3:0] b_addr; logic [7:0] b_wdata;
        logic       e_agnt; logic e_bgnt; logic e_en; logic e_wr; logic [3:0] e_addr; logic [7:0] e_din;
        logic       e_arv; logic [7:0] e_ard; logic e_brv; logic [7:0] e_brd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        a_req = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_wr = 0; b_addr = 0; b_wdata = 0;
    endtask

    initial begin
        // a: req wr addr wdata | b: req wr addr wdata | gA gB en wr addr din | arv ard brv brd
        vecs.push_back(vec_t'{1,1,0,8'h01, 0,0,0,8'h00, 1,0,1,1,0,8'h01, 0,8'h00,0,8'h00});
        vecs.push_back(vec_t'{1,0,0,8'h00, 0,0,0,8'h00, 1,0,1,0,0,8'h00, 0,8'h00,0,8'h00});
        vecs.push_back(vec_t'{0,0,0,8'h00, 0,0,0,8'h00, 0,0,0,0,0,8'h00, 1,8'h01,0,8'h00});
        vecs.push_back(vec_t'{1,1,1,8'hAA, 0,0,0,8'h00, 1,0,1,1,1,8'hAA, 0,8'h00,0,8'h00});
        vecs.push_back(vec_t'{0,0,0,8'h00, 1,1,2,8'h55, 0,1,1,1,2,8'h55, 0,8'h00,0,8'h00});
        vecs.push_back(vec_t'{1,0,1,8'h00, 1,0,2,8'h00, 1,0,1,0,1,8'h00, 0,8'h00,0,8'h00});
        vecs.push_back(vec_t'{1,0,0,8'h99, 1,0,2,8'h00, 0,1,1,0,2,8'h00, 1,8'hAA,0,8'h00});
        vecs.push_back(vec_t'{1,0,0,8'h99, 1,0,1,8'h00, 1,0,1,0,0,8'h99, 0,8'h00,1,8'h55});
        vecs.push_back(vec_t'{0,0,0,8'h00, 1,0,1,8'h00, 0,1,1,0,1,8'h00, 1,8'h01,0,8'h00});
        vecs.push_back(vec_t'{0,0,0,8'h00, 0,0,0,8'h00, 0,0,0,0,0,8'h00, 0,8'h00,1,8'hAA});
        vecs.push_back(vec_t'{1,1,3,8'h3C, 0,0,0,8'h00, 1,0,1,1,3,8'h3C, 0,8'h00,0,8'h00});
        vecs.push_back(vec_t'{0,0,0,8'h00, 1,0,3,8'h00, 0,1,1,0,3,8'h00, 0,8'h00,0,8'h00});
        vecs.push_back(vec_t'{0,0,0,8'h00, 0,0,0,8'h00, 0,0,0,0,0,8'h00, 0,8'h00,1,8'h3C});
        for (int i = 0; i < 5; i++)
            vecs.push_back(vec_t'{0,0,0,8'h00, 0,0,0,8'h00, 0,0,0,0,0,8'h00, 0,8'h00,0,8'h00});
        vecs.push_back(vec_t'{1,0,3,8'h00, 1,0,0,8'h77, 1,0,1,0,3,8'h00, 0,8'h00,0,8'h00});
        vecs.push_back(vec_t'{0,0,0,8'h00, 1,0,0,8'h77, 0,1,1,0,0,8'h77, 1,8'h3C,0,8'h00});
        vecs.push_back(vec_t'{0,0,0,8'h00, 0,0,0,8'h00, 0,0,0,0,0,8'h00, 0,8'h00,1,8'h01});

        // Reset state with both requests high
        idle_inputs();
        rst_n = 0; a_req = 1; b_req = 1;
`ifdef SPRAM_ARB_STATS_EN
        stat_clr = 0;
`endif
        #12;
        check("rst a_gnt", a_gnt, 0);
        check("rst b_gnt", b_gnt, 0);
        check("rst ram_en", ram_en, 0);
        check("rst a_rvalid", a_rvalid, 0);
        check("rst b_rvalid", b_rvalid, 0);
        check("rst a_rdata", a_rdata, 0);
        check("rst b_rdata", b_rdata, 0);
        idle_inputs();
        @(posedge clk); #1 rst_n = 1;

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            a_req = vecs[i].a_req; a_wr = vecs[i].a_wr; a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wdata;
            b_req = vecs[i].b_req; b_wr = vecs[i].b_wr; b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wdata;
            #3;
            check($sformatf("row%0d a_gnt", i), a_gnt, vecs[i].e_agnt);
            check($sformatf("row%0d b_gnt", i), b_gnt, vecs[i].e_bgnt);
            check($sformatf("row%0d ram_en", i), ram_en, vecs[i].e_en);
            check($sformatf("row%0d ram_wr", i), ram_wr, vecs[i].e_wr);
            check($sformatf("row%0d ram_addr", i), ram_addr, vecs[i].e_addr);
            check($sformatf("row%0d ram_din", i), ram_din, vecs[i].e_din);
            check($sformatf("row%0d a_rvalid", i), a_rvalid, vecs[i].e_arv);
            check($sformatf("row%0d a_rdata", i), a_rdata, vecs[i].e_ard);
            check($sformatf("row%0d b_rvalid", i), b_rvalid, vecs[i].e_brv);
            check($sformatf("row%0d b_rdata", i), b_rdata, vecs[i].e_brd);
        end

        // Reset right after a read grant: pending read dropped, outputs zero at once
        @(posedge clk); #1;
        idle_inputs();
        a_req = 1; a_addr = 1;
        #3 check("r5 a_gnt before reset", a_gnt, 1);
        @(posedge clk); #2 rst_n = 0;
        #1;
        check("r5 a_gnt in reset", a_gnt, 0);
        check("r5 ram_en in reset", ram_en, 0);
        check("r5 a_rvalid in reset", a_rvalid, 0);
        check("r5 a_rdata in reset", a_rdata, 0);
        a_req = 0;
        @(posedge clk); #1 rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            #3;
            check($sformatf("r5 a_rvalid after%0d", i), a_rvalid, 0);
            check($sformatf("r5 b_rvalid after%0d", i), b_rvalid, 0);
            @(posedge clk); #1;
        end
        // Pointer returned to A-first by reset (it pointed at B before)
        a_req = 1; a_addr = 0; b_req = 1; b_addr = 0;
        #3;
        check("r5 prio a_gnt", a_gnt, 1);
        check("r5 prio b_gnt", b_gnt, 0);
        @(posedge clk); #1 idle_inputs();

`ifdef SPRAM_ARB_STATS_EN
        stat_clr = 1;
        @(posedge clk); #1 stat_clr = 0;
        #3;
        check("cnt a after clr", a_cnt, 0);
        check("cnt b after clr", b_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            if (i < 3) begin a_req = 1; a_wr = 1; a_addr = 4'(8 + i); a_wdata = 8'(i); end
            else       begin b_req = 1; b_wr = 1; b_addr = 4'(8 + i); b_wdata = 8'(i); end
        end
        @(posedge clk); #1 idle_inputs();
        #3;
        check("cnt a=3", a_cnt, 3);
        check("cnt b=2", b_cnt, 2);
        @(posedge clk); #1;
        a_req = 1; a_wr = 1; a_addr = 4'hF; stat_clr = 1;
        @(posedge clk); #1;
        idle_inputs(); stat_clr = 0;
        #3;
        check("cnt a clr over gnt", a_cnt, 0);
        check("cnt b clr over gnt", b_cnt, 0);
`endif

        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of one `single_port_ram` (ports en, wr, address, in, out).
- Each cycle it grants at most one requester, drives the RAM command, and routes the read data back to the requester that issued the read.
- Sits between the RAM and two independent masters (A, B) so that each master behaves as if it owned the RAM.

Parameters:
- AW, 4, RAM address width
- DW, 8, RAM data width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  requester A command valid
- a_wr  in  1  A: 1=write, 0=read
- a_addr  in  AW  A address
- a_wdata  in  DW  A write data
- a_gnt  out  1  A command accepted this cycle
- a_rvalid  out  1  A read data valid
- a_rdata  out  DW  A read data
- b_req, b_wr, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B
- ram_en  out  1  to RAM en
- ram_wr  out  1  to RAM wr
- ram_addr  out  AW  to RAM address
- ram_din  out  DW  to RAM in
- ram_dout  in  DW  from RAM out

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous and active-low.
- RAM timing:
  - Synchronous: at a rising edge with en=1, wr=1, the RAM writes `in` to `address`.
  - At a rising edge with en=1, wr=0, it registers mem[address] onto `out`.
  - `out` holds its value while en=0.
- Handshake:
  - A requester asserts req and holds wr/addr/wdata stable until it sees gnt=1.
  - The command is accepted at the rising edge that ends the gnt cycle.
  - gnt is combinational from req and the priority pointer. It is never asserted without req.
  - At most one of a_gnt and b_gnt is high in any cycle.
- Arbitration:
  - Registered pointer `prio` (0=A first, 1=B first).
  - Only A requesting: grant A. Only B requesting: grant B.
  - Both requesting: grant the side selected by `prio`.
  - After any grant, `prio` points to the non-granted side.
  - With no grant, `prio` holds.
  - A lone requester may be granted every cycle (full throughput).
- RAM drive:
  - In the grant cycle: ram_en=1, and ram_wr/ram_addr/ram_din come from the granted requester.
  - In an idle cycle: ram_en=0, ram_wr=0, ram_addr=0, ram_din=0.
- Read return:
  - Registered flags `rd_pend_a` and `rd_pend_b` are set at the edge accepting a read from A or B. Otherwise they clear.
  - x_rvalid = rd_pend_x. x_rdata = ram_dout when rd_pend_x=1, else 0.
  - Latency: read granted in cycle k gives rvalid in cycle k+1.
  - Back-to-back reads (A in k, B in k+1) give A rvalid in k+1 and B rvalid in k+2.
- Writes: no response is returned. A read of the same address granted in the next cycle returns the new data.
- Reset values:
  - a_gnt=b_gnt=0 (no req is honoured during reset), a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - ram_en=0, prio=0.
- Reset mid-operation:
  - A pending read is dropped; no rvalid follows deassertion of rst_n.
  - An ungranted request must be re-presented and is then treated as new.
- Request withdrawal: x_req dropped before gnt is legal; the command is simply not issued.

Optional Feature:
- Macro: SPRAM_ARB_STATS_EN
- When defined:
  - Adds outputs a_cnt and b_cnt, 16 bits each: count of grants per requester.
  - Counters saturate at 0xFFFF and reset to 0.
  - Adds input stat_clr: synchronous clear of both counters. stat_clr has priority over an increment in the same cycle.
- When undefined: the counter ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package `spram_arb_pkg`:
  - Constants: SPRAM_AW=4, SPRAM_DW=8, STAT_W=16.
  - Typedef: requester index enum {REQ_A=0, REQ_B=1}.
- Sub-module `rr_pick2`: pointer register plus grant logic (inputs req[1:0]; outputs gnt[1:0] and the updated pointer).
- Top level: the RAM mux, the read-return flags and the optional counters.

Test Plan:
1. Reset then A only: A writes 0x01 to addr 0, then reads addr 0 → a_gnt in both cycles; a_rvalid one cycle after the read grant with a_rdata=0x01; b_rvalid stays 0.
2. Both requesting every cycle with prio=0 → grants alternate A,B,A,B. Preload addr1=0xAA and addr2=0x55; A reads 1 and B reads 2 → a_rdata=0xAA then b_rdata=0x55 in consecutive cycles.
3. Write-then-read hazard: A writes 0x3C to addr 3 in cycle k, B reads addr 3 in cycle k+1 → b_rdata=0x3C in cycle k+2.
4. Idle cycles: no req for 5 cycles → ram_en=0, no rvalid, prio unchanged (next contention grants the previous pointer side).
5. Assert rst_n=0 asynchronously mid-cycle right after a read grant → rvalid never asserts and all outputs go 0 immediately.
6. With SPRAM_ARB_STATS_EN: 3 A grants and 2 B grants give a_cnt=3, b_cnt=2; stat_clr pulsed together with a grant → both counters 0.
